// File: rtl/pwm_compare_pkg.sv
// rtl/pwm_compare_pkg.sv - shared constants and FSM encoding for the PWM compare block
//
// Purpose : default WIDTH/MAX values, 2-bit FSM state encoding and a small
//           helper that tells whether a state drives the PWM compare.
// Ports   : none (package)
package pwm_compare_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int MAX_DEFAULT   = 200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  // RUN and STOP both produce waveform and period_end; IDLE and ARM hold low.
  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/pwm_compare_if.sv
// rtl/pwm_compare_if.sv - duty-value load handshake between a source and the PWM block
//
// Purpose : groups duty_in/duty_valid/duty_ready.
// Signals : duty_in    - new duty value (high counts per period)
//           duty_valid - source offers duty_in
//           duty_ready - pending buffer empty; load accepted when valid && ready
// Modports: master (source side), slave (PWM side)
interface pwm_compare_if
  import pwm_compare_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] duty_in;
  logic             duty_valid;
  logic             duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);

endinterface

// File: rtl/counter_parameter.sv
// rtl/counter_parameter.sv - free-running period counter 0..MAX_VALUE
//
// Purpose : upstream time base for pwm_compare; counts 0..MAX_VALUE then wraps.
// Ports   : clk, RST (async active-low), count - current count value
module counter_parameter #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 200
) (
  input  logic             clk,
  input  logic             RST,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q, count_d;

  assign count   = count_q;
  assign count_d = (count_q == MAX_C) ? '0 : count_q + 1'b1;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/pwm_shadow_reg.sv
// rtl/pwm_shadow_reg.sv - pending/active duty register pair with load handshake
//
// Purpose : a load is captured into the pending register only when it is
//           empty; a commit request moves pending into active.
// Ports   : clk, rst_n (async active-low)
//           load_valid_i, load_data_i, load_ready_o - load handshake
//           commit_i   - move pending to active this edge (if pending is full)
//           duty_act_o - duty value used by the compare
module pwm_shadow_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  input  logic             commit_i,
  output logic [WIDTH-1:0] duty_act_o
);

  logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic [WIDTH-1:0] duty_act_q,  duty_act_d;
  logic             pend_valid_q, pend_valid_d;

  assign load_ready_o = !pend_valid_q;
  assign duty_act_o   = duty_act_q;

  // Commit and accept are mutually exclusive: accept needs an empty buffer,
  // commit needs a full one. A load on a commit edge therefore only fills
  // pending and never reaches active directly.
  always_comb begin
    duty_pend_d  = duty_pend_q;
    duty_act_d   = duty_act_q;
    pend_valid_d = pend_valid_q;
    if (pend_valid_q) begin
      if (commit_i) begin
        duty_act_d   = duty_pend_q;
        pend_valid_d = 1'b0;
      end
    end else if (load_valid_i) begin
      duty_pend_d  = load_data_i;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_pend_q  <= '0;
      duty_act_q   <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      duty_pend_q  <= duty_pend_d;
      duty_act_q   <= duty_act_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: rtl/pwm_compare.sv
// rtl/pwm_compare.sv - PWM compare stage with shadowed duty and start/stop FSM
//
// Purpose : turns an external 0..MAX_VALUE count into a registered PWM
//           waveform. Duty changes only take effect at period boundaries.
// Ports   : clk, RST (async active-low)
//           counter    - count from upstream counter_parameter
//           en         - run request (level)
//           duty       - duty load handshake (slave)
//           pwm_out    - registered waveform, 1 cycle behind counter
//           period_end - registered pulse for the last count of an active period
//           busy       - FSM not in IDLE
module pwm_compare
  import pwm_compare_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MAX_VALUE = MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] counter,
  input  logic             en,
  pwm_compare_if.slave     duty,
  output logic             pwm_out,
  output logic             period_end,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);

  state_e           state_q, state_d;
  logic             pwm_q, pwm_d;
  logic             period_end_q, period_end_d;
  logic             commit;
  logic             wrap;
  logic [WIDTH-1:0] duty_act;

  // Only an exact match wraps; out-of-range counts are still compared.
  assign wrap = (counter == MAX_C);

  pwm_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
    .clk          (clk),
    .rst_n        (RST),
    .load_valid_i (duty.duty_valid),
    .load_data_i  (duty.duty_in),
    .load_ready_o (duty.duty_ready),
    .commit_i     (commit),
    .duty_act_o   (duty_act)
  );

  always_comb begin
    state_d      = state_q;
    commit       = wrap;
    pwm_d        = 1'b0;
    period_end_d = 1'b0;

    if (is_active(state_q)) begin
      pwm_d        = (counter < duty_act);
      period_end_d = wrap;
    end

    case (state_q)
      ST_IDLE: begin
        // Nothing is being generated, so a pending duty can go live at once.
        commit = 1'b1;
        if (en) state_d = ST_ARM;
      end
      ST_ARM: begin
        // Leaving on wrap makes the first RUN sample land on counter=0.
        if (!en)       state_d = ST_IDLE;
        else if (wrap) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Re-enable wins over wrap so a running waveform never gaps.
        if (en)        state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      pwm_q        <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign period_end = period_end_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_compare.sv
// tb/tb_pwm_compare.sv - directed self-checking bench for pwm_compare (WIDTH=4, MAX_VALUE=9)
module tb_pwm_compare;

  localparam int W = 4;
  localparam int M = 9;

  logic         clk;
  logic         RST;
  logic         en;
  logic [W-1:0] cnt;
  logic         pwm_out;
  logic         period_end;
  logic         busy;

  int  checks;
  int  errors;
  bit  exp_pend;

  pwm_compare_if #(.WIDTH(W)) duty_if ();

  counter_parameter #(.WIDTH(W), .MAX_VALUE(M)) u_cnt (
    .clk   (clk),
    .RST   (RST),
    .count (cnt)
  );

  pwm_compare #(.WIDTH(W), .MAX_VALUE(M)) dut (
    .clk        (clk),
    .RST        (RST),
    .counter    (cnt),
    .en         (en),
    .duty       (duty_if),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance until the counter presents value v (bounded).
  task automatic wait_count(input int v);
    for (int n = 0; n < 40; n++) begin
      if (cnt == W'(v)) break;
      tick();
    end
    chk($sformatf("wait_count %0d", v), 32'(cnt), 32'(v));
  endtask

  // One full period starting with counter=0 presented. Sample i reflects
  // the counter value i presented before the edge.
  task automatic run_period(input int duty, input int la = -1, input int lv = 0,
                            input int lb = -1, input int lbv = 0,
                            input int eoff = -1, input int eon = -1);
    for (int i = 0; i < 10; i++) begin
      bit prev;
      bit ld;
      ld = (i == la) || (i == lb);
      if (ld) begin
        duty_if.duty_valid = 1'b1;
        duty_if.duty_in    = (i == la) ? W'(lv) : W'(lbv);
      end
      if (i == eoff) en = 1'b0;
      if (i == eon)  en = 1'b1;
      tick();
      duty_if.duty_valid = 1'b0;
      prev = exp_pend;
      if (i == 9 && prev)    exp_pend = 1'b0;
      else if (ld && !prev)  exp_pend = 1'b1;
      chk($sformatf("pwm_out duty=%0d c=%0d", duty, i), 32'(pwm_out), (i < duty) ? 32'd1 : 32'd0);
      chk($sformatf("period_end duty=%0d c=%0d", duty, i), 32'(period_end), 32'(i == 9));
      chk($sformatf("duty_ready duty=%0d c=%0d", duty, i), 32'(duty_if.duty_ready), 32'(!exp_pend));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_pend = 1'b0;
    RST = 1'b1;
    en  = 1'b0;
    duty_if.duty_in    = '0;
    duty_if.duty_valid = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 RST = 1'b0;
    #1;
    chk("reset pwm_out", 32'(pwm_out), 32'd0);
    chk("reset period_end", 32'(period_end), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset duty_ready", 32'(duty_if.duty_ready), 32'd1);
    chk("reset counter", 32'(cnt), 32'd0);
    tick();
    tick();
    RST = 1'b1;

    // Load duty=3 while IDLE: pending, then active on the next edge.
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in    = 4'd3;
    tick();
    duty_if.duty_valid = 1'b0;
    chk("idle load ready low", 32'(duty_if.duty_ready), 32'd0);
    tick();
    chk("idle commit ready high", 32'(duty_if.duty_ready), 32'd1);
    chk("idle busy", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    chk("arm busy", 32'(busy), 32'd1);
    chk("arm pwm_out", 32'(pwm_out), 32'd0);
    wait_count(9);
    tick();
    chk("arm wrap period_end", 32'(period_end), 32'd0);
    chk("arm wrap pwm_out", 32'(pwm_out), 32'd0);
    run_period(3);

    // Mid-period load of 7 at counter=4.
    run_period(3, 4, 7);
    run_period(7);

    // Second load while pending is ignored; load on a wrap edge waits a period.
    run_period(7, 2, 5, 6, 9);
    run_period(5, 9, 2);
    run_period(5);
    run_period(2);

    // Duty boundaries: 0%, exactly period, above period.
    run_period(2, 0, 0);
    run_period(0, 0, 10);
    run_period(10, 0, 15);
    run_period(15, 0, 3);
    run_period(3);

    // en dropped at counter=5: period completes, then IDLE.
    run_period(3, -1, 0, -1, 0, 5);
    chk("stop->idle busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("idle pwm_out k=%0d", k), 32'(pwm_out), 32'd0);
      chk($sformatf("idle busy k=%0d", k), 32'(busy), 32'd0);
      chk($sformatf("idle period_end k=%0d", k), 32'(period_end), 32'd0);
    end
    en = 1'b1;
    tick();
    wait_count(9);
    tick();
    chk("rearm busy", 32'(busy), 32'd1);
    chk("rearm pwm_out", 32'(pwm_out), 32'd0);
    // en drops at 5, returns at 7: no gap into the next period.
    run_period(3, -1, 0, -1, 0, 5, 7);
    chk("stop->run busy", 32'(busy), 32'd1);
    run_period(3);

    // Reset mid-period with a pending value.
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in    = 4'd7;
    tick();
    duty_if.duty_valid = 1'b0;
    chk("pre-reset pending", 32'(duty_if.duty_ready), 32'd0);
    tick();
    chk("pre-reset pwm high", 32'(pwm_out), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("midreset pwm_out", 32'(pwm_out), 32'd0);
    chk("midreset period_end", 32'(period_end), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset duty_ready", 32'(duty_if.duty_ready), 32'd1);
    exp_pend = 1'b0;
    tick();
    RST = 1'b1;
    wait_count(9);
    tick();
    chk("post-reset busy", 32'(busy), 32'd1);
    // Pending 7 was discarded and active reset to 0: waveform stays low.
    run_period(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_compare.md
PWM_COMPARE -- requirements
Module: pwm_compare

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter/duty bit width.
REQ-002 SHALL have parameter MAX_VALUE, default 200, meaning terminal count of the upstream counter_parameter instance.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on posedge clk.
REQ-004 SHALL have port RST, input, 1, meaning the reset: asynchronous, active-low.
REQ-005 SHALL have port counter, input, WIDTH, meaning the count value from the upstream counter_parameter, which counts 0..MAX_VALUE and then wraps to 0.
REQ-006 SHALL have port en, input, 1, meaning the PWM run request (level).
REQ-007 SHALL have port duty_in, input, WIDTH, meaning the new duty value (number of high counts per period).
REQ-008 SHALL have port duty_valid, input, 1, meaning duty_in is offered.
REQ-009 SHALL have port duty_ready, output, 1, meaning the pending buffer is empty; a load is accepted on a cycle where duty_valid and duty_ready are both 1.
REQ-010 SHALL have port pwm_out, output, 1, meaning the registered PWM waveform.
REQ-011 SHALL have port period_end, output, 1, meaning a registered one-cycle pulse at the end of each active period.
REQ-012 SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-013 SHALL keep two registers: duty_pend with flag pend_valid, and duty_act; duty_ready = !pend_valid.
REQ-014 SHALL define wrap as counter == MAX_VALUE.
REQ-015 SHALL implement the FSM states IDLE, ARM, RUN, STOP.
REQ-016 IDLE: en=1 -> ARM; pend_valid=1 -> duty_act<=duty_pend and pend_valid<=0 on the next edge.
REQ-017 ARM: en=0 -> IDLE; wrap -> RUN, so that the first RUN sample is taken at counter=0.
REQ-018 RUN: en=0 -> STOP, otherwise stay in RUN.
REQ-019 STOP: en=1 -> RUN; wrap -> IDLE, so the current period completes; en=1 takes priority over wrap.
REQ-020 In ARM, RUN or STOP, on wrap with pend_valid=1: duty_act<=duty_pend and pend_valid<=0, so the new duty takes effect from counter=0 of the next period. No mid-period duty change.
REQ-021 duty_valid asserted on a wrap edge while pend_valid=0 SHALL load the pending register only; there is no bypass to duty_act.
REQ-022 While pend_valid=1, duty_valid SHALL be ignored (no overwrite); the source holds the value until duty_ready.
REQ-023 In RUN and STOP: pwm_out <= (counter < duty_act), unsigned compare, giving 1-cycle latency from counter to pwm_out.
REQ-024 In IDLE and ARM: pwm_out <= 0.
REQ-025 Duty boundary values: duty_act=0 SHALL give 0% (pwm_out constant low); duty_act > MAX_VALUE SHALL give 100% (constant high); no clamping of duty_in.
REQ-026 period_end <= wrap && (state==RUN || state==STOP); it SHALL never assert in IDLE or ARM.
REQ-027 Counter values above MAX_VALUE SHALL be compared as-is and SHALL NOT cause wrap.

Reset
REQ-028 RST=0 SHALL immediately force: state=IDLE, pwm_out=0, period_end=0, busy=0, duty_act=0, duty_pend=0, pend_valid=0 (duty_ready=1).
REQ-029 Reset asserted mid-period SHALL discard a pending duty value; after release the block waits in IDLE for en.

Structure
REQ-030 FSM state encodings (2 bits) SHALL live in the shared defines include alongside the WIDTH_*/MAX_* constants.
REQ-031 The pending/active duty pair with its handshake SHALL be one sub-module, pwm_shadow_reg (WIDTH param).
REQ-032 Top-level tests SHALL instantiate pwm_compare downstream of counter_parameter using the same WIDTH and MAX_VALUE.

Verification (WIDTH=4, MAX_VALUE=9, period 10 cycles)
REQ-033 Load duty=3 in IDLE, en=1 -> ARM until counter=9; pwm_out high for exactly 3 cycles (samples at counters 0,1,2) of each 10; period_end pulses at each counter=9.
REQ-034 Load duty=7 while running with duty=3 at counter=4 -> duty_ready drops; current period stays at 3 high; next period has 7 high; duty_ready returns to 1 after the wrap.
REQ-035 duty=0 -> pwm_out constantly 0; duty=10 and duty=15 -> constantly 1; period_end still pulses every 10 cycles.
REQ-036 en dropped at counter=5 -> period completes (STOP), IDLE after the counter=9 edge, then pwm_out=0 and busy=0; re-asserting en at counter=7 in STOP -> stays running with no gap.
REQ-037 Second duty_valid while pend_valid=1 -> ignored, first value applied; duty_valid on a wrap edge -> applied only at the following wrap.
REQ-038 RST pulsed low mid-period with a pending value -> all outputs 0 immediately, duty_ready=1, pending value lost.
